// File: rtl/lcd_rx_pkg.sv
// rtl/lcd_rx_pkg.sv - shared types, widths and colour repack for the RGB LCD receiver
package lcd_rx_pkg;

  localparam int COORD_W = 11;
  localparam logic [COORD_W-1:0] COORD_MAX = '1;

  typedef enum logic [1:0] {
    SEARCH  = 2'd0,
    MEASURE = 2'd1,
    LOCKED  = 2'd2
  } rx_state_e;

  // One registered sample of the video bus; hs/vs are held normalised to active-high.
  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
  } lcd_sample_t;

  function automatic logic [15:0] rgb888_to_565(input logic [23:0] rgb);
    return {rgb[23:19], rgb[15:10], rgb[7:3]};
  endfunction

endpackage

// File: rtl/lcd_rgb_rx_if.sv
// rtl/lcd_rgb_rx_if.sv - parallel DE-mode RGB888 video bus
interface lcd_rgb_rx_if;

  logic        lcd_de;
  logic        lcd_hs;
  logic        lcd_vs;
  logic [23:0] lcd_rgb;

  modport master (output lcd_de, lcd_hs, lcd_vs, lcd_rgb);
  modport slave  (input  lcd_de, lcd_hs, lcd_vs, lcd_rgb);

endinterface

// File: rtl/lcd_rx_fmt_meas.sv
// rtl/lcd_rx_fmt_meas.sv - frame size measurement, two-frame lock FSM and VS watchdog
module lcd_rx_fmt_meas
  import lcd_rx_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               vs_edge,
  input  logic               line_end,
  input  logic               bad_evt,
  input  logic [COORD_W-1:0] x_cnt,
  input  logic [COORD_W-1:0] y_cnt,
  output rx_state_e          state,
  output logic [COORD_W-1:0] h_meas,
  output logic [COORD_W-1:0] v_meas,
  output logic               fmt_err_evt
);

  localparam logic [31:0] WD_LIMIT = 32'(TIMEOUT_CYCLES);

  rx_state_e          state_q, state_d;
  logic [COORD_W-1:0] h_q, h_d, v_q, v_d;
  logic [COORD_W-1:0] prev_h_q, prev_h_d, prev_v_q, prev_v_d;
  logic               prev_valid_q, prev_valid_d;
  logic [COORD_W-1:0] first_w_q, first_w_d;
  logic               frame_bad_q, frame_bad_d;
  logic [31:0]        wd_q, wd_d;

  logic [COORD_W-1:0] line_w;
  logic               frame_ok, dims_match, timeout;

  assign line_w     = x_cnt + COORD_W'(1);
  assign frame_ok   = !frame_bad_q && (y_cnt != '0);
  assign dims_match = prev_valid_q && (first_w_q == prev_h_q) && (y_cnt == prev_v_q);
  assign timeout    = (wd_q == WD_LIMIT);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= SEARCH;
      h_q          <= '0;
      v_q          <= '0;
      prev_h_q     <= '0;
      prev_v_q     <= '0;
      prev_valid_q <= 1'b0;
      first_w_q    <= '0;
      frame_bad_q  <= 1'b0;
      wd_q         <= '0;
    end else begin
      state_q      <= state_d;
      h_q          <= h_d;
      v_q          <= v_d;
      prev_h_q     <= prev_h_d;
      prev_v_q     <= prev_v_d;
      prev_valid_q <= prev_valid_d;
      first_w_q    <= first_w_d;
      frame_bad_q  <= frame_bad_d;
      wd_q         <= wd_d;
    end
  end

  // A real VS edge beats a simultaneous watchdog expiry so SEARCH can always be left.
  always_comb begin
    state_d = state_q;
    case (state_q)
      SEARCH:  if (vs_edge) state_d = MEASURE;
      MEASURE: if (vs_edge && frame_ok && dims_match) state_d = LOCKED;
      LOCKED:  if (vs_edge && !(frame_ok && dims_match)) state_d = MEASURE;
      default: state_d = SEARCH;
    endcase
    if (timeout && !vs_edge) state_d = SEARCH;
  end

  always_comb begin
    state       = state_q;
    h_meas      = h_q;
    v_meas      = v_q;
    fmt_err_evt = (state_q == LOCKED) && vs_edge && !(frame_ok && dims_match);
  end

  always_comb begin
    h_d          = h_q;
    v_d          = v_q;
    prev_h_d     = prev_h_q;
    prev_v_d     = prev_v_q;
    prev_valid_d = prev_valid_q;
    first_w_d    = first_w_q;
    frame_bad_d  = frame_bad_q;
    wd_d         = timeout ? wd_q : wd_q + 32'd1;
    if (line_end && (y_cnt == '0)) first_w_d = line_w;
    if (bad_evt || (line_end && (y_cnt != '0) && (line_w != first_w_q))) frame_bad_d = 1'b1;
    if (vs_edge) begin
      wd_d        = '0;
      first_w_d   = '0;
      frame_bad_d = 1'b0;
      if (state_q != SEARCH) begin
        h_d = first_w_q;
        v_d = y_cnt;
      end
      if ((state_q == MEASURE) && !(frame_ok && dims_match)) begin
        prev_h_d     = first_w_q;
        prev_v_d     = y_cnt;
        prev_valid_d = frame_ok;
      end
      // A broken locked frame must be followed by two clean frames before relocking.
      if (fmt_err_evt) prev_valid_d = 1'b0;
    end else if (timeout) begin
      prev_valid_d = 1'b0;
    end
  end

endmodule

// File: rtl/lcd_rgb_rx.sv
// rtl/lcd_rgb_rx.sv - RGB888 DE-mode receiver: sync stages, pixel counters and RGB565 output
module lcd_rgb_rx
  import lcd_rx_pkg::*;
#(
  parameter bit SYNC_ACTIVE_LOW = 1'b1,
  parameter int TIMEOUT_CYCLES  = 1000000
) (
  input  logic               lcd_pclk,
  input  logic               rst,
  lcd_rgb_rx_if.slave        vid,
  output logic               pix_valid,
  output logic [15:0]        pix_data,
  output logic [COORD_W-1:0] pix_x,
  output logic [COORD_W-1:0] pix_y,
  output logic               pix_sof,
  output logic               pix_eol,
  output logic [COORD_W-1:0] h_meas,
  output logic [COORD_W-1:0] v_meas,
  output logic               locked,
  output logic               fmt_err
);

  lcd_sample_t        s0_q, s0_d, s1_q, s1_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic               sof_pend_q, sof_pend_d;

  logic               valid_q, valid_d, sof_q, sof_d, eol_q, eol_d;
  logic               lock_q, lock_d, err_q, err_d;
  logic [15:0]        data_q, data_d;
  logic [COORD_W-1:0] px_q, px_d, py_q, py_d, hm_q, hm_d, vm_q, vm_d;

  logic               vs_edge, line_start, line_end, bad_evt, pix_ok, fmt_err_evt;
  rx_state_e          state;
  logic [COORD_W-1:0] h_cur, v_cur;

  assign vs_edge    = s0_q.vs & ~s1_q.vs;
  assign line_start = s0_q.de & ~s1_q.de;
  assign line_end   = s1_q.de & ~s0_q.de;
  // Saturated counters and HS asserted inside active video both poison the frame.
  assign bad_evt    = (s1_q.de && (x_q == COORD_MAX)) || (line_end && (y_q == COORD_MAX))
                    || (s1_q.de && s1_q.hs);
  assign pix_ok     = s1_q.de && (state != SEARCH);

  lcd_rx_fmt_meas #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_fmt_meas (
    .clk         (lcd_pclk),
    .rst         (rst),
    .vs_edge     (vs_edge),
    .line_end    (line_end),
    .bad_evt     (bad_evt),
    .x_cnt       (x_q),
    .y_cnt       (y_q),
    .state       (state),
    .h_meas      (h_cur),
    .v_meas      (v_cur),
    .fmt_err_evt (fmt_err_evt)
  );

  always_comb begin
    s0_d.de  = vid.lcd_de;
    s0_d.hs  = vid.lcd_hs ^ SYNC_ACTIVE_LOW;
    s0_d.vs  = vid.lcd_vs ^ SYNC_ACTIVE_LOW;
    s0_d.rgb = vid.lcd_rgb;
    s1_d     = s0_q;

    x_d = x_q;
    if (line_start) x_d = '0;
    else if (s1_q.de && (x_q != COORD_MAX)) x_d = x_q + COORD_W'(1);

    y_d = y_q;
    if (vs_edge) y_d = '0;
    else if (line_end && (y_q != COORD_MAX)) y_d = y_q + COORD_W'(1);

    sof_pend_d = sof_pend_q;
    if (vs_edge) sof_pend_d = 1'b1;
    else if (s1_q.de) sof_pend_d = 1'b0;

    valid_d = pix_ok;
    data_d  = pix_ok ? rgb888_to_565(s1_q.rgb) : 16'd0;
    px_d    = pix_ok ? x_q : '0;
    py_d    = pix_ok ? y_q : '0;
    sof_d   = pix_ok && sof_pend_q;
    eol_d   = pix_ok && !s0_q.de;
    hm_d    = h_cur;
    vm_d    = v_cur;
    lock_d  = (state == LOCKED);
    err_d   = fmt_err_evt;
  end

  always_ff @(posedge lcd_pclk) begin
    if (rst) begin
      s0_q       <= '0;
      s1_q       <= '0;
      x_q        <= '0;
      y_q        <= '0;
      sof_pend_q <= 1'b0;
      valid_q    <= 1'b0;
      data_q     <= '0;
      px_q       <= '0;
      py_q       <= '0;
      sof_q      <= 1'b0;
      eol_q      <= 1'b0;
      hm_q       <= '0;
      vm_q       <= '0;
      lock_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      s0_q       <= s0_d;
      s1_q       <= s1_d;
      x_q        <= x_d;
      y_q        <= y_d;
      sof_pend_q <= sof_pend_d;
      valid_q    <= valid_d;
      data_q     <= data_d;
      px_q       <= px_d;
      py_q       <= py_d;
      sof_q      <= sof_d;
      eol_q      <= eol_d;
      hm_q       <= hm_d;
      vm_q       <= vm_d;
      lock_q     <= lock_d;
      err_q      <= err_d;
    end
  end

  assign pix_valid = valid_q;
  assign pix_data  = data_q;
  assign pix_x     = px_q;
  assign pix_y     = py_q;
  assign pix_sof   = sof_q;
  assign pix_eol   = eol_q;
  assign h_meas    = hm_q;
  assign v_meas    = vm_q;
  assign locked    = lock_q;
  assign fmt_err   = err_q;

endmodule

// File: tb/tb_lcd_rgb_rx.sv
// tb/tb_lcd_rgb_rx.sv - directed bench for lcd_rgb_rx with 8x4 frames and hand-computed results
module tb_lcd_rgb_rx;

  logic        clk;
  logic        rst;
  logic        pix_valid, pix_sof, pix_eol, locked, fmt_err;
  logic [15:0] pix_data;
  logic [10:0] pix_x, pix_y, h_meas, v_meas;

  lcd_rgb_rx_if vid_if ();

  lcd_rgb_rx #(
    .SYNC_ACTIVE_LOW (1'b1),
    .TIMEOUT_CYCLES  (64)
  ) dut (
    .lcd_pclk  (clk),
    .rst       (rst),
    .vid       (vid_if),
    .pix_valid (pix_valid),
    .pix_data  (pix_data),
    .pix_x     (pix_x),
    .pix_y     (pix_y),
    .pix_sof   (pix_sof),
    .pix_eol   (pix_eol),
    .h_meas    (h_meas),
    .v_meas    (v_meas),
    .locked    (locked),
    .fmt_err   (fmt_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_chk, n_err;
  int          ci, nv, fv, nfe, mx, my;
  logic        mon_en, lk_s;
  logic [10:0] h_s, v_s;
  logic [23:0] rgb_cur;
  logic [15:0] exp565;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_pix"}, 32'({pix_valid, pix_data, pix_x}), 32'd0);
    chk({tag, "_ctl"}, 32'({pix_y, pix_sof, pix_eol, fmt_err, locked}), 32'd0);
    chk({tag, "_meas"}, 32'({h_meas, v_meas}), 32'd0);
  endtask

  // One pixel clock: drive at the falling edge, look at outputs at the next falling edge.
  task automatic cyc(input bit de, input bit vs_act);
    logic sof_e, eol_e;
    vid_if.lcd_de  = de;
    vid_if.lcd_hs  = de;
    vid_if.lcd_vs  = ~vs_act;
    vid_if.lcd_rgb = de ? rgb_cur : 24'd0;
    @(posedge clk);
    @(negedge clk);
    if (pix_valid) begin
      nv++;
      if (fv < 0) fv = ci;
      if (mon_en) begin
        sof_e = (mx == 0) && (my == 0);
        eol_e = (mx == 7);
        chk("pix_pos", 32'({pix_x, pix_y, pix_sof, pix_eol}),
            32'({11'(mx), 11'(my), sof_e, eol_e}));
        chk("pix_data", 32'(pix_data), 32'(exp565));
        mx++;
        if (mx == 8) begin
          mx = 0;
          my++;
        end
      end
    end
    if (fmt_err) nfe++;
    if (ci == 2) begin
      lk_s = locked;
      h_s  = h_meas;
      v_s  = v_meas;
    end
    ci++;
  endtask

  // 8x4 frame (row 1 may be w1 wide); coin puts the VS start on the first pixel.
  task automatic frame(input int w1, input bit coin, input int rst_row);
    int w;
    ci = 0; nv = 0; fv = -1; nfe = 0; mx = 0; my = 0;
    if (!coin) repeat (2) cyc(1'b0, 1'b1);
    for (int r = 0; r < 4; r++) begin
      w = (r == 1) ? w1 : 8;
      for (int c = 0; c < w; c++) begin
        if (r == rst_row && c == 3) rst = 1'b1;
        cyc(1'b1, coin && (r == 0) && (c < 2));
        if (rst) begin
          rst = 1'b0;
          chk_zero("mid_rst");
          nv = 0;
        end
      end
      repeat (2) cyc(1'b0, 1'b0);
    end
    repeat (2) cyc(1'b0, 1'b0);
  endtask

  initial begin
    n_chk = 0; n_err = 0; mon_en = 1'b0; rgb_cur = 24'h0; exp565 = 16'h0;
    ci = 0; nv = 0; fv = -1; nfe = 0; mx = 0; my = 0;
    vid_if.lcd_de = 1'b0; vid_if.lcd_hs = 1'b0; vid_if.lcd_vs = 1'b1; vid_if.lcd_rgb = 24'h0;
    rst = 1'b1;
    @(negedge clk);
    repeat (2) cyc(1'b0, 1'b0);
    chk_zero("reset");
    rst = 1'b0;

    rgb_cur = 24'hABCDEF; nv = 0;
    repeat (8) cyc(1'b1, 1'b0);
    repeat (4) cyc(1'b0, 1'b0);
    chk("pre_vs_valid", 32'(nv), 32'd0);

    mon_en = 1'b1;
    rgb_cur = 24'hFF8040; exp565 = 16'hFC08;
    frame(8, 1'b0, -1);
    chk("f1_count", 32'(nv), 32'd32);
    chk("f1_latency", 32'(fv), 32'd4);
    chk("f1_open_lock", 32'(lk_s), 32'd0);

    rgb_cur = 24'h123456; exp565 = 16'h11AA;
    frame(8, 1'b0, -1);
    chk("f2_count", 32'(nv), 32'd32);
    chk("f2_open_lock", 32'(lk_s), 32'd0);
    chk("f2_open_dims", 32'({h_s, v_s}), 32'({11'd8, 11'd4}));

    rgb_cur = 24'h00FF00; exp565 = 16'h07E0;
    frame(8, 1'b0, -1);
    chk("f3_open_lock", 32'(lk_s), 32'd1);
    chk("f3_open_dims", 32'({h_s, v_s}), 32'({11'd8, 11'd4}));
    chk("f3_fmt_err", 32'(nfe), 32'd0);

    mon_en = 1'b0;
    frame(9, 1'b0, -1);
    chk("f4_open_lock", 32'(lk_s), 32'd1);

    mon_en = 1'b1;
    rgb_cur = 24'hFF8040; exp565 = 16'hFC08;
    frame(8, 1'b0, -1);
    chk("f5_fmt_err", 32'(nfe), 32'd1);
    chk("f5_open_lock", 32'(lk_s), 32'd0);
    chk("f5_open_dims", 32'({h_s, v_s}), 32'({11'd8, 11'd4}));
    frame(8, 1'b0, -1);
    chk("f6_open_lock", 32'(lk_s), 32'd0);
    frame(8, 1'b0, -1);
    chk("f7_open_lock", 32'(lk_s), 32'd1);

    mon_en = 1'b0;
    ci = 0; nv = 0; nfe = 0;
    repeat (3) begin
      repeat (8) cyc(1'b1, 1'b0);
      repeat (2) cyc(1'b0, 1'b0);
    end
    nv = 0;
    repeat (4) begin
      repeat (8) cyc(1'b1, 1'b0);
      repeat (2) cyc(1'b0, 1'b0);
    end
    chk("wd_lock_before", 32'(lk_s), 32'd1);
    chk("wd_valid", 32'(nv), 32'd0);
    chk("wd_locked", 32'(locked), 32'd0);
    chk("wd_fmt_err", 32'(nfe), 32'd0);
    chk("wd_h_meas", 32'(h_meas), 32'd8);

    mon_en = 1'b1;
    frame(8, 1'b0, -1);
    chk("f8_count", 32'(nv), 32'd32);
    chk("f8_open_lock", 32'(lk_s), 32'd0);
    frame(8, 1'b0, -1);
    chk("f9_open_lock", 32'(lk_s), 32'd0);

    mon_en = 1'b0;
    frame(8, 1'b0, 2);
    chk("f10_open_lock", 32'(lk_s), 32'd1);
    chk("f10_after_rst_valid", 32'(nv), 32'd0);

    mon_en = 1'b1;
    rgb_cur = 24'h123456; exp565 = 16'h11AA;
    frame(8, 1'b1, -1);
    chk("coin_latency", 32'(fv), 32'd2);
    chk("coin_count", 32'(nv), 32'd32);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/lcd_rgb_rx.md
# lcd_rgb_rx

Receive-side counterpart of the RGB LCD timing driver. It samples a parallel DE-mode RGB888 video stream (DE/HS/VS plus 24-bit data) on the pixel clock and recovers per-pixel coordinates. It repacks data to RGB565, measures active width and height, and declares format lock once two consecutive frames agree. It sits between an external RGB source (or the driver's loop-back for self-test) and downstream frame-buffer or resize logic.

## Interface
Parameters:
- SYNC_ACTIVE_LOW, 1: polarity of lcd_hs/lcd_vs; 1 = active-low.
- TIMEOUT_CYCLES, 1000000: lcd_pclk cycles with no VS active edge before the lock is dropped.

Ports:
- lcd_pclk  in  1  pixel clock; the only clock.
- rst  in  1  reset; synchronous, active-high.
- lcd_de  in  1  data enable; a pixel is valid while high.
- lcd_hs  in  1  line sync; used only for line_err checking.
- lcd_vs  in  1  frame sync.
- lcd_rgb  in  24  {R[7:0],G[7:0],B[7:0]}.
- pix_valid  out  1  output pixel strobe.
- pix_data  out  16  RGB565 = {R[7:3],G[7:2],B[7:3]}.
- pix_x  out  11  column of the current pixel, 0-based.
- pix_y  out  11  row of the current pixel, 0-based.
- pix_sof  out  1  high with the first pixel of a frame.
- pix_eol  out  1  high with the last pixel of a line.
- h_meas  out  11  active width of the last completed frame.
- v_meas  out  11  active height of the last completed frame.
- locked  out  1  format lock.
- fmt_err  out  1  one-cycle pulse on a format mismatch while locked.

## Operation
- Input stage: s0 registers all inputs. s1 registers s0. Outputs register from s1.
- VS edge: vs_edge = s0.vs active and s1.vs inactive, after polarity normalisation.
- Line start: s0.de high and s1.de low. Line end: s1.de high and s0.de low.
- Coordinates:
  - x counter clears at line start and increments per DE pixel. It saturates at 2047.
  - y counter clears at vs_edge and increments at each line end. It saturates at 2047.
- pix_eol is high for the s1 pixel when s0.de = 0.
- pix_sof is high for the first DE pixel after vs_edge.
- pix_valid = s1.de when the state is not SEARCH. Data after reset is suppressed until the first VS edge.
- Line consistency: every line in a frame is compared with the frame's first-line width. Any difference sets an internal frame_bad flag. frame_bad is also set if any counter saturates.
- FSM states and transitions:
  - SEARCH: on vs_edge, go to MEASURE.
  - MEASURE, on vs_edge:
    - Latch h_meas/v_meas.
    - If the frame is good, has ≥1 line, and matches the previous frame's dimensions, go to LOCKED (locked = 1).
    - Otherwise store the dimensions as the new previous frame and stay in MEASURE.
  - LOCKED, on vs_edge:
    - Latch h_meas/v_meas.
    - On any mismatch or frame_bad: pulse fmt_err, clear locked, go to MEASURE.
- Watchdog:
  - A counter clears on every vs_edge.
  - When it reaches TIMEOUT_CYCLES, from any state: go to SEARCH, clear locked, and leave h_meas/v_meas unchanged.
  - fmt_err does not pulse on watchdog expiry.
- vs_edge coinciding with a DE pixel: the VS edge takes effect first. That pixel is y = 0, x = 0, and pix_sof = 1.
- Reset, including mid-frame:
  - All outputs go to 0 and all counters clear. State goes to SEARCH.
  - Output resumes only after the next vs_edge.

## Timing
- Latency: a pixel present before edge E0 appears on the outputs after edge E2, valid for one cycle.
- h_meas/v_meas/locked update 3 edges after the VS transition is presented. fmt_err pulses on that same edge.
- One pixel per cycle is accepted. There is no backpressure, and downstream must accept every pix_valid.
- Minimum blanking: 1 cycle of DE low between lines. 2 cycles of VS active before a frame's first DE.

## Structure
- Package lcd_rx_pkg contains:
  - COORD_W = 11.
  - The enum of states SEARCH, MEASURE, LOCKED.
  - Function rgb888_to_565.
- Sub-module lcd_rx_fmt_meas holds the width/height comparison, the lock FSM and the watchdog. It takes vs_edge, line_end and the x/y counts.
- The top level holds the sync stages, counters and output registers.

## Test plan
- Reset: 8×4 frames, 2-cycle line blanking, active-low sync.
  - Required: locked rises after the 2nd frame's closing VS edge. h_meas = 8, v_meas = 4.
  - pix_x runs 0..7, pix_eol is high at x = 7, pix_sof is high only at (0,0).
- Data: lcd_rgb = 24'hFF8040.
  - Required: pix_data = 16'hFC08, 2 cycles after input.
- Locked, then a 9-pixel line in the next frame.
  - Required: fmt_err pulses once at that frame's end. locked drops, then relocks after 2 further clean 8×4 frames.
- Locked, then VS held inactive for TIMEOUT_CYCLES (set to 64).
  - Required: locked = 0, no fmt_err, pix_valid stays low until the next VS edge.
- rst asserted mid-line in the 3rd row of a locked stream.
  - Required: all outputs are 0 next cycle. Pixels remaining in that frame produce no pix_valid.
- VS edge in the same cycle as the first DE.
  - Required: that pixel is output with pix_sof = 1, x = 0, y = 0.
